// File: rtl/cc_pkg.sv
// Shared encodings for the condition-code flag stack: instruction kinds, ALU op class, flag bit layout.
// Macro CC_NV_EN widens the flag word from {Z,C} to {V,N,Z,C}.
package cc_pkg;

  localparam logic [3:0] KIND_RR   = 4'b0000;
  localparam logic [3:0] KIND_RI   = 4'b0001;
  localparam logic [3:0] KIND_SH   = 4'b0010;
  localparam logic [3:0] KIND_RETI = 4'b1000;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LOGIC} op_cls_e;

  function automatic op_cls_e fn3_class(input logic [2:0] fn3);
    op_cls_e cls;
    case (fn3)
      3'b000, 3'b001: cls = OP_ADD;
      3'b010, 3'b011: cls = OP_SUB;
      default:        cls = OP_LOGIC;
    endcase
    return cls;
  endfunction

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
`ifdef CC_NV_EN
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int NFLAGS = 4;
`else
  localparam int NFLAGS = 2;
`endif

endpackage

// File: rtl/cc_flag_stack_save.sv
// LIFO of saved flag words for nested interrupts; push+pop together leaves the stack untouched.
module cc_save_stack #(
  parameter int DEPTH  = 4,
  parameter int NFLAGS = 2,
  parameter int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              ck,
  input  logic              res,
  input  logic              en_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [NFLAGS-1:0] push_data_i,
  output logic [NFLAGS-1:0] top_o,
  output logic [SP_W-1:0]   sp_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, top_idx;
  logic              err_q, err_d, wr_en;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q - 1'b1;
  assign top_o   = empty_o ? '0 : mem_q[AW'(top_idx)];
  assign sp_o    = sp_q;
  assign err_o   = err_q;

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (en_i) begin
      if (pop_i) begin
        if (empty_o)      err_d = 1'b1;
        else if (!push_i) sp_d  = sp_q - 1'b1;
      end else if (push_i) begin
        if (full_o) begin
          err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      if (wr_en) mem_q[AW'(sp_q)] <= push_data_i;
    end
  end

endmodule

// File: rtl/cc_flag_stack.sv
// Condition-code register with built-in interrupt save stack.
// CC_NV_EN: adds N/V flags and makes C the unsigned carry; otherwise C carries signed overflow for add/sub.
module cc_flag_stack
  import cc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int RA_W  = 3,
  parameter  int DEPTH = 4,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             res,
  input  logic             ck2,
  input  logic [3:0]       kind,
  input  logic [2:0]       fn3,
  input  logic             int_ack,
  input  logic             store_ex,
  input  logic [RA_W-1:0]  Waddr,
  input  logic [WIDTH-1:0] Wdata,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] _const,
  output logic             cc_c,
  output logic             cc_z,
  output logic             cc_n,
  output logic             cc_v,
  output logic [SP_W-1:0]  sp,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  op_cls_e           op;
  logic [WIDTH-1:0]  opb;
  logic              is_alu, is_sh, is_reti, en;
  logic              sa, sb, sw, ovf, carry, zero;
  logic [NFLAGS-1:0] flags_q, flags_d, calc_flags, top_flags;
  logic              unused_bits;

  assign op      = fn3_class(fn3);
  assign en      = ~ck2;
  assign is_alu  = (kind == KIND_RR) || (kind == KIND_RI);
  assign is_sh   = (kind == KIND_SH);
  assign is_reti = (kind == KIND_RETI);
  assign opb     = (kind == KIND_RI) ? _const : rd2;

  assign sa   = rd1[WIDTH-1];
  assign sb   = opb[WIDTH-1];
  assign sw   = Wdata[WIDTH-1];
  assign ovf  = is_alu && (((op == OP_ADD) && (sa == sb) && (sw != sa)) ||
                           ((op == OP_SUB) && (sa != sb) && (sw != sa)));
  assign zero = (Wdata == '0) || (Waddr == '0);
  assign unused_bits = ^{rd1[WIDTH-2:0], opb[WIDTH-2:0]};

  always_comb begin
    carry = 1'b0;
    if (is_sh)                         carry = store_ex;
`ifdef CC_NV_EN
    else if (is_alu && op != OP_LOGIC) carry = store_ex;
`else
    else if (is_alu && op != OP_LOGIC) carry = ovf;
`endif
  end

  always_comb begin
    calc_flags = flags_q;
    if (is_alu || is_sh) begin
      calc_flags[FLAG_C] = carry;
      calc_flags[FLAG_Z] = zero;
`ifdef CC_NV_EN
      calc_flags[FLAG_N] = sw;
      calc_flags[FLAG_V] = ovf;
`endif
    end
  end

  // A RETI restores from the stack top; with int_ack as well, the stack keeps that entry.
  always_comb begin
    flags_d = flags_q;
    if (en) begin
      if (is_reti) begin
        if (!stk_empty) flags_d = top_flags;
      end else begin
        flags_d = calc_flags;
      end
    end
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) flags_q <= '0;
    else      flags_q <= flags_d;
  end

  cc_save_stack #(
    .DEPTH (DEPTH),
    .NFLAGS(NFLAGS),
    .SP_W  (SP_W)
  ) u_stack (
    .ck         (ck),
    .res        (res),
    .en_i       (en),
    .push_i     (int_ack),
    .pop_i      (is_reti),
    .push_data_i(calc_flags),
    .top_o      (top_flags),
    .sp_o       (sp),
    .full_o     (stk_full),
    .empty_o    (stk_empty),
    .err_o      (stk_err)
  );

  assign cc_c = flags_q[FLAG_C];
  assign cc_z = flags_q[FLAG_Z];
`ifdef CC_NV_EN
  assign cc_n = flags_q[FLAG_N];
  assign cc_v = flags_q[FLAG_V];
`else
  assign cc_n = 1'b0;
  assign cc_v = 1'b0;
`endif

endmodule

// File: tb/tb_cc_flag_stack.sv
// Self-checking bench for cc_flag_stack: directed scenarios then randomized traffic against a queue-based model.
module tb_cc_flag_stack;

`ifdef CC_NV_EN
  localparam bit NV = 1'b1;
`else
  localparam bit NV = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       ck = 1'b0, res = 1'b0, ck2 = 1'b0;
  logic [3:0] kind = 4'b0100;
  logic [2:0] fn3 = '0;
  logic       int_ack = 1'b0, store_ex = 1'b0;
  logic [2:0] Waddr = '0;
  logic [7:0] Wdata = '0, rd1 = '0, rd2 = '0, cst = '0;
  logic       cc_c, cc_z, cc_n, cc_v, stk_full, stk_empty, stk_err;
  logic [2:0] sp;

  int checks = 0;
  int errors = 0;

  typedef struct packed {bit c; bit z; bit n; bit v;} fl_t;
  fl_t cur;
  fl_t stk[$];
  bit  m_err;

  cc_flag_stack dut (
    .ck(ck), .res(res), .ck2(ck2), .kind(kind), .fn3(fn3), .int_ack(int_ack),
    .store_ex(store_ex), .Waddr(Waddr), .Wdata(Wdata), .rd1(rd1), .rd2(rd2),
    ._const(cst), .cc_c(cc_c), .cc_z(cc_z), .cc_n(cc_n), .cc_v(cc_v), .sp(sp),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_c"}, cc_c, cur.c);
    chk({tag, "_z"}, cc_z, cur.z);
    chk({tag, "_n"}, cc_n, cur.n);
    chk({tag, "_v"}, cc_v, cur.v);
    chk({tag, "_sp"}, sp, stk.size());
    chk({tag, "_full"}, stk_full, stk.size() == DEPTH);
    chk({tag, "_empty"}, stk_empty, stk.size() == 0);
    chk({tag, "_err"}, stk_err, m_err);
  endtask

  task automatic model_reset();
    cur = '0;
    stk.delete();
    m_err = 1'b0;
  endtask

  // Flags from the arithmetic meaning of the instruction: overflow means the true signed result leaves [-128,127].
  task automatic model_step();
    fl_t nf;
    int  a, b, r;
    bit  ovf;
    nf = cur;
    if (ck2) return;
    if (kind == 4'b0000 || kind == 4'b0001 || kind == 4'b0010) begin
      a   = $signed(rd1);
      b   = (kind == 4'b0001) ? $signed(cst) : $signed(rd2);
      ovf = 1'b0;
      nf.z = (Wdata == 0) || (Waddr == 0);
      nf.n = NV ? Wdata[7] : 1'b0;
      if (kind == 4'b0010) begin
        nf.c = store_ex;
      end else if (fn3 < 4) begin
        r    = (fn3 < 2) ? a + b : a - b;
        ovf  = (r > 127) || (r < -128);
        nf.c = NV ? store_ex : ovf;
      end else begin
        nf.c = 1'b0;
      end
      nf.v = NV ? ovf : 1'b0;
    end
    if (kind == 4'b1000) begin
      if (stk.size() == 0) m_err = 1'b1;
      else begin
        cur = stk[$];
        if (!int_ack) void'(stk.pop_back());
      end
    end else begin
      cur = nf;
      if (int_ack) begin
        if (stk.size() < DEPTH) stk.push_back(nf);
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic set_in(input logic [3:0] k, input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] w,
                        input logic sx, input logic [2:0] wa, input logic ia, input logic q);
    kind = k; fn3 = f; rd1 = a; rd2 = b; cst = c; Wdata = w;
    store_ex = sx; Waddr = wa; int_ack = ia; ck2 = q;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge ck);
    #1;
    check_all(tag);
  endtask

  task automatic rand_in();
    logic [7:0] b;
    logic [8:0] s;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 9: kind = 4'b0000;
      2, 3:    kind = 4'b0001;
      4:       kind = 4'b0010;
      5, 6:    kind = 4'b1000;
      7:       kind = 4'b0100;
      default: kind = 4'b1111;
    endcase
    fn3 = 3'($urandom); rd1 = 8'($urandom); rd2 = 8'($urandom); cst = 8'($urandom);
    Waddr = 3'($urandom);
    Wdata = 8'($urandom); store_ex = 1'($urandom);
    if ($urandom_range(0, 7) == 0) Wdata = '0;
    b = (kind == 4'b0001) ? cst : rd2;
    if ((kind == 4'b0000 || kind == 4'b0001) && fn3 < 4) begin
      s = (fn3 < 2) ? {1'b0, rd1} + {1'b0, b} : {1'b0, rd1} - {1'b0, b};
      Wdata = s[7:0];
      store_ex = s[8];
    end
    int_ack = ($urandom_range(0, 3) == 0);
    ck2 = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #1 res = 1'b1;

    set_in(4'b0000, 3'b000, 8'h70, 8'h20, 8'h00, 8'h90, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc("add_ovf");
    chk("add_ovf_c_direct", cc_c, NV ? 1'b0 : 1'b1);
    chk("add_ovf_v_direct", cc_v, NV);

    set_in(4'b0001, 3'b010, 8'h05, 8'h00, 8'h05, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0);
    cyc("sub_zero");
    chk("sub_zero_z_direct", cc_z, 1'b1);
    set_in(4'b0000, 3'b100, 8'h00, 8'h00, 8'h00, 8'h11, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("logic_r0");

    set_in(4'b0000, 3'b000, 8'h70, 8'h20, 8'h00, 8'h90, 1'b0, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("qual_hold");
    chk("qual_hold_z_direct", cc_z, 1'b1);

    set_in(4'b0010, 3'b000, 8'h00, 8'h00, 8'h00, 8'h40, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc("nest_set");
    set_in(4'b0100, 3'b000, 8'h00, 8'h00, 8'h00, 8'h40, 1'b0, 3'd1, 1'b1, 1'b0);
    cyc("nest_push1");
    set_in(4'b0010, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc("nest_shift");
    set_in(4'b0100, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0);
    cyc("nest_push2");
    set_in(4'b1000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc("nest_reti1");
    cyc("nest_reti2");
    chk("nest_reti2_c_direct", cc_c, 1'b1);
    chk("nest_reti2_empty_direct", stk_empty, 1'b1);

    set_in(4'b0100, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("fill");
    chk("fill_sp_direct", sp, 3'd4);
    chk("fill_err_direct", stk_err, 1'b1);
    set_in(4'b1000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("drain");

    set_in(4'b0010, 3'b000, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 3'd1, 1'b1, 1'b0);
    cyc("both_push1");
    set_in(4'b0010, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0);
    cyc("both_push2");
    set_in(4'b0010, 3'b000, 8'h00, 8'h00, 8'h00, 8'h03, 1'b1, 3'd4, 1'b0, 1'b0);
    cyc("both_change");
    set_in(4'b1000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0);
    cyc("both_reti_ack");
    chk("both_sp_direct", sp, 3'd2);
    chk("both_z_direct", cc_z, 1'b1);

    set_in(4'b0010, 3'b000, 8'h00, 8'h00, 8'h00, 8'h05, 1'b1, 3'd3, 1'b1, 1'b0);
    cyc("pre_rst");
    set_in(4'b0100, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    #2 res = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 res = 1'b1;

    for (int i = 0; i < 300; i++) begin
      rand_in();
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
